// File: rtl/wb_write_port_arbiter.sv
// Register-file write-port arbiter: the WB-stage pipeline write and a small FIFO of
// auxiliary (mul/div, HI/LO) results share one port. A starvation counter can steal one cycle.
module wb_write_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        PipeRegWrite,
  input  logic [4:0]  PipeWriteReg,
  input  logic [31:0] PipeWriteData,
  input  logic        AuxValid,
  input  logic [4:0]  AuxWriteReg,
  input  logic [31:0] AuxWriteData,
  output logic        AuxReady,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        PipeStall
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_L    = CW'(DEPTH);
  localparam logic [3:0]    MAX_WAIT_L = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_PIPE  = 2'd1,
    GNT_AUX   = 2'd2,
    GNT_FORCE = 2'd3
  } grant_e;

  logic [4:0]    ent_reg_q  [DEPTH];
  logic [4:0]    ent_reg_d  [DEPTH];
  logic [31:0]   ent_data_q [DEPTH];
  logic [31:0]   ent_data_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;

  grant_e grant;
  logic   pipe_req;
  logic   fifo_empty;
  logic   aux_accept;
  logic   push;
  logic   pop;
  logic   force_gnt;

  // Aux handshake: an entry transfers on any cycle where AuxValid && AuxReady at the
  // rising edge. AuxReady looks only at the registered count, never at this cycle's pop,
  // so a full FIFO refuses even when it is draining. Accepted writes to $0 are dropped.
  always_comb begin
    pipe_req   = PipeRegWrite && (PipeWriteReg != 5'd0);
    fifo_empty = (count_q == '0);
    AuxReady   = !Rst && (count_q < DEPTH_L);
    aux_accept = AuxValid && AuxReady;
    push       = aux_accept && (AuxWriteReg != 5'd0);
    force_gnt  = !fifo_empty && (wait_cnt_q >= MAX_WAIT_L);
  end

  always_comb begin
    grant = GNT_NONE;
    if (Rst)            grant = GNT_NONE;
    else if (force_gnt) grant = GNT_FORCE;
    else if (pipe_req)  grant = GNT_PIPE;
    else if (!fifo_empty) grant = GNT_AUX;
    pop = (grant == GNT_FORCE) || (grant == GNT_AUX);
  end

  always_comb begin
    RegWrite      = 1'b0;
    WriteRegister = 5'd0;
    WriteData     = 32'd0;
    PipeStall     = 1'b0;
    case (grant)
      GNT_PIPE: begin
        RegWrite      = 1'b1;
        WriteRegister = PipeWriteReg;
        WriteData     = PipeWriteData;
      end
      GNT_AUX: begin
        RegWrite      = 1'b1;
        WriteRegister = ent_reg_q[rd_ptr_q];
        WriteData     = ent_data_q[rd_ptr_q];
      end
      GNT_FORCE: begin
        // The held pipe request is replayed next cycle because WB inputs stay frozen.
        RegWrite      = 1'b1;
        WriteRegister = ent_reg_q[rd_ptr_q];
        WriteData     = ent_data_q[rd_ptr_q];
        PipeStall     = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ent_reg_d  = ent_reg_q;
    ent_data_d = ent_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      ent_reg_d[wr_ptr_q]  = AuxWriteReg;
      ent_data_d[wr_ptr_q] = AuxWriteData;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Counts consecutive cycles the head has been passed over; cleared by any pop.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (pop || fifo_empty) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != 4'hF) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wait_cnt_q <= 4'd0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Entry storage needs no reset: count gates every read of it.
  always_ff @(posedge Clk) begin
    ent_reg_q  <= ent_reg_d;
    ent_data_q <= ent_data_d;
  end

endmodule

// File: tb/tb_wb_write_port_arbiter.sv
// Bench for wb_write_port_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a queue-based model of the arbitration rules.
module tb_wb_write_port_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        Clk;
  logic        Rst;
  logic        PipeRegWrite;
  logic [4:0]  PipeWriteReg;
  logic [31:0] PipeWriteData;
  logic        AuxValid;
  logic [4:0]  AuxWriteReg;
  logic [31:0] AuxWriteData;
  logic        AuxReady;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        PipeStall;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [36:0] exp_q[$];
  int          wait_m = 0;
  logic        last_stall = 1'b0;

  wb_write_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .Clk(Clk), .Rst(Rst),
    .PipeRegWrite(PipeRegWrite), .PipeWriteReg(PipeWriteReg), .PipeWriteData(PipeWriteData),
    .AuxValid(AuxValid), .AuxWriteReg(AuxWriteReg), .AuxWriteData(AuxWriteData),
    .AuxReady(AuxReady), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .PipeStall(PipeStall)
  );

  // clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic pw, input logic [4:0] preg, input logic [31:0] pdata,
                        input logic av, input logic [4:0] areg, input logic [31:0] adata);
    PipeRegWrite  = pw;
    PipeWriteReg  = preg;
    PipeWriteData = pdata;
    AuxValid      = av;
    AuxWriteReg   = areg;
    AuxWriteData  = adata;
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge Clk);
  endtask

  task automatic expect_write(input string name, input logic rw, input logic [4:0] r,
                              input logic [31:0] d, input logic st);
    check({name, "_regwrite"}, 32'(RegWrite), 32'(rw));
    check({name, "_reg"}, 32'(WriteRegister), 32'(r));
    check({name, "_data"}, WriteData, d);
    check({name, "_stall"}, 32'(PipeStall), 32'(st));
  endtask

  // Reference model: FIFO as a queue, wait as a plain integer; outputs follow the
  // priority rules force > pipe > queued. Evaluated mid-cycle with inputs stable.
  always @(negedge Clk) begin
    logic        e_rw, e_st, e_rdy, preq, forced, do_pop;
    logic [4:0]  e_reg;
    logic [31:0] e_dat;
    int          size_before;
    e_rw = 1'b0; e_st = 1'b0; e_rdy = 1'b0; e_reg = 5'd0; e_dat = 32'd0;
    do_pop = 1'b0;
    if (Rst) begin
      exp_q.delete();
      wait_m = 0;
    end else begin
      size_before = exp_q.size();
      e_rdy  = size_before < DEPTH;
      preq   = PipeRegWrite && (PipeWriteReg != 5'd0);
      forced = (size_before != 0) && (wait_m >= MAX_WAIT);
      if (forced) begin
        {e_reg, e_dat} = exp_q[0];
        e_rw = 1'b1; e_st = 1'b1; do_pop = 1'b1;
      end else if (preq) begin
        e_rw = 1'b1; e_reg = PipeWriteReg; e_dat = PipeWriteData;
      end else if (size_before != 0) begin
        {e_reg, e_dat} = exp_q[0];
        e_rw = 1'b1; do_pop = 1'b1;
      end
      if (do_pop) void'(exp_q.pop_front());
      if (AuxValid && e_rdy && (AuxWriteReg != 5'd0)) exp_q.push_back({AuxWriteReg, AuxWriteData});
      if (do_pop || size_before == 0) wait_m = 0;
      else if (wait_m < 15) wait_m = wait_m + 1;
    end
    check("m_auxready", 32'(AuxReady), 32'(e_rdy));
    check("m_regwrite", 32'(RegWrite), 32'(e_rw));
    check("m_reg", 32'(WriteRegister), 32'(e_reg));
    check("m_data", WriteData, e_dat);
    check("m_stall", 32'(PipeStall), 32'(e_st));
    last_stall = e_st;
  end

  initial begin
    int ph_prob;
    // reset with aux traffic present
    Rst = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h0000_0088);
    repeat (2) begin
      at_neg();
      check("rst_auxready", 32'(AuxReady), 32'd0);
      check("rst_regwrite", 32'(RegWrite), 32'd0);
      next_cycle();
    end
    Rst = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    at_neg();
    check("post_rst_auxready", 32'(AuxReady), 32'd1);
    expect_write("post_rst", 1'b0, 5'd0, 32'd0, 1'b0);
    next_cycle();

    // idle pipe: aux entry written the next cycle
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hDEAD_BEEF);
    at_neg();
    expect_write("idle_n", 1'b0, 5'd0, 32'd0, 1'b0);
    next_cycle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    at_neg();
    expect_write("idle_n1", 1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0);
    next_cycle();

    // pipe priority, FIFO fills, then drains in order
    set_in(1'b1, 5'd3, 32'd100, 1'b1, 5'd9, 32'h0000_0909);
    at_neg();
    expect_write("prio_a", 1'b1, 5'd3, 32'd100, 1'b0);
    next_cycle();
    set_in(1'b1, 5'd3, 32'd101, 1'b1, 5'd10, 32'h0000_0A0A);
    at_neg();
    expect_write("prio_b", 1'b1, 5'd3, 32'd101, 1'b0);
    check("prio_b_ready", 32'(AuxReady), 32'd1);
    next_cycle();
    set_in(1'b1, 5'd3, 32'd102, 1'b0, 5'd0, 32'd0);
    at_neg();
    expect_write("prio_c", 1'b1, 5'd3, 32'd102, 1'b0);
    check("prio_full_ready", 32'(AuxReady), 32'd0);
    next_cycle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    at_neg();
    expect_write("drain_9", 1'b1, 5'd9, 32'h0000_0909, 1'b0);
    next_cycle();
    at_neg();
    expect_write("drain_10", 1'b1, 5'd10, 32'h0000_0A0A, 1'b0);
    check("drain_ready", 32'(AuxReady), 32'd1);
    next_cycle();

    // starvation: 4 denied cycles, forced grant, then held pipe value
    set_in(1'b1, 5'd5, 32'h500, 1'b1, 5'd12, 32'h0000_1234);
    at_neg();
    expect_write("starve_0", 1'b1, 5'd5, 32'h500, 1'b0);
    next_cycle();
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, 5'd5, 32'h500 + 32'(i), 1'b0, 5'd0, 32'd0);
      at_neg();
      expect_write("starve_deny", 1'b1, 5'd5, 32'h500 + 32'(i), 1'b0);
      next_cycle();
    end
    set_in(1'b1, 5'd5, 32'h505, 1'b0, 5'd0, 32'd0);
    at_neg();
    expect_write("starve_force", 1'b1, 5'd12, 32'h0000_1234, 1'b1);
    next_cycle();
    at_neg();
    expect_write("starve_held", 1'b1, 5'd5, 32'h505, 1'b0);
    next_cycle();

    // $0 handling
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
    at_neg();
    expect_write("zero_q", 1'b0, 5'd0, 32'd0, 1'b0);
    next_cycle();
    set_in(1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'd0);
    at_neg();
    expect_write("zero_pipe", 1'b1, 5'd7, 32'h77, 1'b0);
    next_cycle();
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5A5A);
    at_neg();
    check("zero_aux_ready", 32'(AuxReady), 32'd1);
    expect_write("zero_aux", 1'b0, 5'd0, 32'd0, 1'b0);
    next_cycle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    at_neg();
    check("zero_aux_ready2", 32'(AuxReady), 32'd1);
    expect_write("zero_aux2", 1'b0, 5'd0, 32'd0, 1'b0);
    next_cycle();

    // reset with two entries queued
    set_in(1'b1, 5'd4, 32'h40, 1'b1, 5'd20, 32'h20);
    next_cycle();
    set_in(1'b1, 5'd4, 32'h41, 1'b1, 5'd21, 32'h21);
    next_cycle();
    Rst = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    at_neg();
    check("midrst_ready", 32'(AuxReady), 32'd0);
    expect_write("midrst", 1'b0, 5'd0, 32'd0, 1'b0);
    next_cycle();
    Rst = 1'b0;
    at_neg();
    check("midrst_rel_ready", 32'(AuxReady), 32'd1);
    expect_write("midrst_rel", 1'b0, 5'd0, 32'd0, 1'b0);
    next_cycle();
    at_neg();
    expect_write("midrst_rel2", 1'b0, 5'd0, 32'd0, 1'b0);
    next_cycle();

    // random traffic; pipe inputs are held across a stall as the pipeline would
    for (int i = 0; i < 3000; i++) begin
      case (i / 500)
        0, 3:    ph_prob = 40;
        1, 4:    ph_prob = 85;
        default: ph_prob = 97;
      endcase
      Rst = ($urandom_range(0, 149) == 0);
      if (!last_stall) begin
        PipeRegWrite  = ($urandom_range(0, 99) < ph_prob);
        PipeWriteReg  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        PipeWriteData = $urandom;
      end
      AuxValid     = ($urandom_range(0, 2) != 0);
      AuxWriteReg  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      AuxWriteData = $urandom;
      next_cycle();
    end
    Rst = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (4) next_cycle();
    at_neg();
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
